// File: rtl/cheriot_dmem_responder.sv
// Tagged data-memory responder for the CHERIoT data port.
// Holds one capability tag bit per 32-bit word. Each granted request is
// answered after a fixed latency, and responses come back in grant order.
// The protocol checker is in the same file and is instantiated by the top.

module cheriot_dmem_responder_chk #(
  parameter int unsigned RespLatency = 1
) (
  input logic        clk_i,
  input logic        rst_ni,
  input logic        data_req_i,
  input logic        data_is_cap_i,
  input logic        data_we_i,
  input logic [3:0]  data_be_i,
  input logic [31:0] data_addr_i,
  input logic [32:0] data_wdata_i,
  input logic        data_gnt_o,
  input logic        data_rvalid_o,
  input logic [32:0] data_rdata_o,
  input logic        data_err_o
);

  // A response must trace back to a handshake exactly RespLatency cycles earlier
  a_rvalid_after_grant : assert property (@(posedge clk_i) disable iff (!rst_ni)
    data_rvalid_o |-> $past(data_req_i & data_gnt_o, RespLatency));

  // Payload is quiet whenever no response is presented
  a_idle_payload_zero : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !data_rvalid_o |-> (data_rdata_o == 33'd0) && !data_err_o);

  // Initiator keeps a waiting request stable until it is granted
  a_req_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (data_req_i & ~data_gnt_o) |=> data_req_i && $stable(data_addr_i) &&
      $stable(data_we_i) && $stable(data_be_i) && $stable(data_wdata_i) &&
      $stable(data_is_cap_i));

endmodule

module cheriot_dmem_responder #(
  parameter logic [31:0] BaseAddr    = 32'h2000_0000,
  parameter int unsigned Depth       = 1024,
  parameter int unsigned RespLatency = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  input  logic        data_is_cap_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [32:0] data_wdata_i,
  input  logic        stall_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [32:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int unsigned AddrW      = $clog2(Depth);
  localparam logic [32:0] DepthBytes = 33'(Depth) << 2;

  logic [32:0]      mem_q [Depth];
  logic             gnt_s;
  logic             hs_s;
  logic             err_s;
  logic             in_range_s;
  logic [31:0]      offset_s;
  logic [AddrW-1:0] idx_s;
  logic [32:0]      word_s;
  logic [32:0]      wr_word_s;
  logic             resp_valid_d;
  logic [32:0]      resp_rdata_d;
  logic             resp_err_d;
  logic             valid_q [RespLatency];
  logic [32:0]      rdata_q [RespLatency];
  logic             err_q   [RespLatency];

  // The grant is held low during reset, so no handshake can occur while rst_ni is low.
  assign gnt_s      = data_req_i & ~stall_i & rst_ni;
  assign hs_s       = data_req_i & gnt_s;
  assign data_gnt_o = gnt_s;

  // Address decode and error classification for the request on the port
  always_comb begin
    offset_s   = data_addr_i - BaseAddr;
    // The first term also guarantees that the subtraction did not wrap.
    in_range_s = (data_addr_i >= BaseAddr) && ({1'b0, offset_s} < DepthBytes);
    err_s      = (data_addr_i[1:0] != 2'b00) | ~in_range_s |
                 (data_is_cap_i & (data_be_i != 4'hF)) | (data_be_i == 4'h0);
    idx_s      = offset_s[AddrW+1:2];
  end

  // Merge store bytes into the addressed word; only a full capability store keeps a tag
  always_comb begin
    word_s        = mem_q[idx_s];
    wr_word_s     = word_s;
    wr_word_s[32] = data_is_cap_i & (data_be_i == 4'hF) & data_wdata_i[32];
    for (int b = 0; b < 4; b++) begin
      if (data_be_i[b]) begin
        wr_word_s[8*b +: 8] = data_wdata_i[8*b +: 8];
      end else begin
        wr_word_s[8*b +: 8] = word_s[8*b +: 8];
      end
    end
  end

  // Build the response for a handshake this cycle; no handshake leaves it all zero
  always_comb begin
    resp_valid_d = 1'b0;
    resp_rdata_d = 33'd0;
    resp_err_d   = 1'b0;
    if (!hs_s) begin
      resp_valid_d = 1'b0;
    end else if (err_s) begin
      resp_valid_d = 1'b1;
      resp_err_d   = 1'b1;
    end else if (data_we_i) begin
      resp_valid_d = 1'b1;
    end else begin
      resp_valid_d = 1'b1;
      resp_rdata_d = {data_is_cap_i & word_s[32], word_s[31:0]};
    end
  end

  // Word array: cleared on reset, written by error-free granted stores
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= 33'd0;
      end
    end else if (hs_s & data_we_i & ~err_s) begin
      mem_q[idx_s] <= wr_word_s;
    end
  end

  // Fixed-latency response pipeline that advances every cycle; reset drops in-flight responses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(RespLatency); i++) begin
        valid_q[i] <= 1'b0;
        rdata_q[i] <= 33'd0;
        err_q[i]   <= 1'b0;
      end
    end else begin
      valid_q[0] <= resp_valid_d;
      rdata_q[0] <= resp_rdata_d;
      err_q[0]   <= resp_err_d;
      for (int i = 1; i < int'(RespLatency); i++) begin
        valid_q[i] <= valid_q[i-1];
        rdata_q[i] <= rdata_q[i-1];
        err_q[i]   <= err_q[i-1];
      end
    end
  end

  assign data_rvalid_o = valid_q[RespLatency-1];
  assign data_rdata_o  = rdata_q[RespLatency-1];
  assign data_err_o    = err_q[RespLatency-1];

  cheriot_dmem_responder_chk #(
    .RespLatency (RespLatency)
  ) u_chk (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .data_req_i    (data_req_i),
    .data_is_cap_i (data_is_cap_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .data_err_o    (data_err_o)
  );

endmodule

// File: tb/tb_cheriot_dmem_responder.sv
// Scoreboard bench for cheriot_dmem_responder.
// Two instances, with response latencies 1 and 3, receive the same stimulus.
// Each instance has its own queue of expected responses, including the cycle in which each response is due.

module tb_cheriot_dmem_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req = 1'b0;
  logic        is_cap = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = 32'd0;
  logic [32:0] wdata = 33'd0;
  logic        stall = 1'b0;

  logic        gnt1, rv1, er1;
  logic [32:0] rd1;
  logic        gnt3, rv3, er3;
  logic [32:0] rd3;

  typedef struct {
    logic [32:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk_i = ~clk_i;

  // cycle index used for the latency checks
  always @(posedge clk_i) cyc <= cyc + 1;

  cheriot_dmem_responder #(.RespLatency(1)) u_dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_req_i(req), .data_is_cap_i(is_cap),
    .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .stall_i(stall), .data_gnt_o(gnt1), .data_rvalid_o(rv1),
    .data_rdata_o(rd1), .data_err_o(er1));

  cheriot_dmem_responder #(.RespLatency(3)) u_dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_req_i(req), .data_is_cap_i(is_cap),
    .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .stall_i(stall), .data_gnt_o(gnt3), .data_rvalid_o(rv3),
    .data_rdata_o(rd3), .data_err_o(er3));

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare each presented response against the head of its queue
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (rv1) begin
        if (q1.size() == 0) begin
          check("l1_unexpected_rvalid", 72'(1), 72'(0));
        end else begin
          exp_t e;
          e = q1.pop_front();
          check("l1_rdata", 72'(rd1), 72'(e.rdata));
          check("l1_err", 72'(er1), 72'(e.err));
          check("l1_cycle", 72'(cyc), 72'(e.due));
        end
      end
      if (rv3) begin
        if (q3.size() == 0) begin
          check("l3_unexpected_rvalid", 72'(1), 72'(0));
        end else begin
          exp_t e;
          e = q3.pop_front();
          check("l3_rdata", 72'(rd3), 72'(e.rdata));
          check("l3_err", 72'(er3), 72'(e.err));
          check("l3_cycle", 72'(cyc), 72'(e.due));
        end
      end
    end
  end

  // Present one request, optionally stalled first, and record its expected response
  task automatic issue(input logic w, input logic c, input logic [3:0] b,
                       input logic [31:0] a, input logic [32:0] d,
                       input logic [32:0] exp_rdata, input logic exp_err,
                       input int stall_cycles);
    exp_t e;
    @(negedge clk_i);
    req    = 1'b1;
    we     = w;
    is_cap = c;
    be     = b;
    addr   = a;
    wdata  = d;
    stall  = (stall_cycles > 0);
    for (int i = 0; i < stall_cycles; i++) begin
      #1;
      check("gnt_stalled_l1", 72'(gnt1), 72'(0));
      check("gnt_stalled_l3", 72'(gnt3), 72'(0));
      @(negedge clk_i);
    end
    stall = 1'b0;
    #1;
    check("gnt_l1", 72'(gnt1), 72'(1));
    check("gnt_l3", 72'(gnt3), 72'(1));
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.due   = cyc + 1;
    q1.push_back(e);
    e.due   = cyc + 3;
    q3.push_back(e);
  endtask

  task automatic idle(input int n);
    @(negedge clk_i);
    req   = 1'b0;
    stall = 1'b0;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rvalid1"}, 72'(rv1), 72'(0));
    check({tag, "_rdata1"}, 72'(rd1), 72'(0));
    check({tag, "_err1"}, 72'(er1), 72'(0));
    check({tag, "_rvalid3"}, 72'(rv3), 72'(0));
    check({tag, "_rdata3"}, 72'(rd3), 72'(0));
    check({tag, "_gnt1"}, 72'(gnt1), 72'(0));
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_ni = 1'b1;

    // 1: cap store, then a cap load in the next cycle
    issue(1'b1, 1'b1, 4'hF, 32'h2000_0010, 33'h1_DEAD_BEEF, 33'h0, 1'b0, 0);
    issue(1'b0, 1'b1, 4'hF, 32'h2000_0010, 33'h0, 33'h1_DEAD_BEEF, 1'b0, 0);
    // 3: non-cap load hides the tag
    issue(1'b0, 1'b0, 4'hF, 32'h2000_0010, 33'h0, 33'h0_DEAD_BEEF, 1'b0, 0);
    // 2: partial store clears the tag
    issue(1'b1, 1'b0, 4'b0001, 32'h2000_0010, 33'h0_0000_0011, 33'h0, 1'b0, 0);
    issue(1'b0, 1'b1, 4'hF, 32'h2000_0010, 33'h0, 33'h0_DEAD_BE11, 1'b0, 0);
    // 4: error cases
    issue(1'b0, 1'b0, 4'hF, 32'h2000_0011, 33'h0, 33'h0, 1'b1, 0);
    issue(1'b1, 1'b0, 4'hF, 32'h2000_1000, 33'h0_CAFE_F00D, 33'h0, 1'b1, 0);
    issue(1'b1, 1'b1, 4'h3, 32'h2000_0010, 33'h1_0000_0000, 33'h0, 1'b1, 0);
    issue(1'b0, 1'b0, 4'h0, 32'h2000_0010, 33'h0, 33'h0, 1'b1, 0);
    issue(1'b0, 1'b0, 4'hF, 32'h1FFF_FFFC, 33'h0, 33'h0, 1'b1, 0);
    issue(1'b0, 1'b1, 4'hF, 32'h2000_0000, 33'h0, 33'h0, 1'b0, 0);
    issue(1'b0, 1'b1, 4'hF, 32'h2000_0010, 33'h0, 33'h0_DEAD_BE11, 1'b0, 0);
    // last valid word
    issue(1'b1, 1'b1, 4'hF, 32'h2000_0FFC, 33'h1_A5A5_A5A5, 33'h0, 1'b0, 0);
    issue(1'b0, 1'b1, 4'hF, 32'h2000_0FFC, 33'h0, 33'h1_A5A5_A5A5, 1'b0, 0);
    // 5: stores, then four back-to-back loads and a stalled load
    issue(1'b1, 1'b0, 4'hF, 32'h2000_0020, 33'h0_1111_1111, 33'h0, 1'b0, 0);
    issue(1'b1, 1'b1, 4'hF, 32'h2000_0024, 33'h1_2222_2222, 33'h0, 1'b0, 0);
    issue(1'b1, 1'b0, 4'b1100, 32'h2000_0028, 33'h0_3333_9999, 33'h0, 1'b0, 0);
    issue(1'b0, 1'b1, 4'hF, 32'h2000_0020, 33'h0, 33'h0_1111_1111, 1'b0, 0);
    issue(1'b0, 1'b1, 4'hF, 32'h2000_0024, 33'h0, 33'h1_2222_2222, 1'b0, 0);
    issue(1'b0, 1'b0, 4'hF, 32'h2000_0024, 33'h0, 33'h0_2222_2222, 1'b0, 0);
    issue(1'b0, 1'b0, 4'hF, 32'h2000_0028, 33'h0, 33'h0_3333_0000, 1'b0, 0);
    issue(1'b0, 1'b1, 4'hF, 32'h2000_0010, 33'h0, 33'h0_DEAD_BE11, 1'b0, 2);
    idle(6);
    check("drained_l1", 72'(q1.size()), 72'(0));
    check("drained_l3", 72'(q3.size()), 72'(0));

    // 6: reset with responses in flight
    issue(1'b0, 1'b0, 4'hF, 32'h2000_0020, 33'h0, 33'h0_1111_1111, 1'b0, 0);
    issue(1'b0, 1'b1, 4'hF, 32'h2000_0024, 33'h0, 33'h1_2222_2222, 1'b0, 0);
    req = 1'b0;
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    q1.delete();
    q3.delete();
    repeat (2) @(negedge clk_i);
    check_reset_outputs("midreset");
    rst_ni = 1'b1;
    idle(4);
    issue(1'b0, 1'b1, 4'hF, 32'h2000_0024, 33'h0, 33'h0, 1'b0, 0);
    issue(1'b0, 1'b1, 4'hF, 32'h2000_0010, 33'h0, 33'h0, 1'b0, 0);
    idle(6);
    check("final_empty_l1", 72'(q1.size()), 72'(0));
    check("final_empty_l3", 72'(q3.size()), 72'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
